// File: rtl/hyperbus_ctrl.sv
// hyperbus_ctrl -- HyperBus transaction sequencer.
//
// Takes one read or write request at a time from the host side and walks it
// through the HyperBus phases: CS# setup, three command/address words, initial
// latency, data burst, CS# hold and read-write recovery. Drives the 16-bit DDR
// word stream and output enable of the 8-bit bidirectional pad block, plus
// CS# and the memory clock enable.
//
// Optional feature (compile-time macro): HYPERBUS_CTRL_TIMEOUT_EN
//   defined   : a read that sees no RWDS strobe for TIMEOUT cycles pulses err_o
//               and closes the transaction normally (CSH, RCV, done_o).
//   undefined : reads wait for strobes indefinitely, err_o tied to 0.
//
// Parameters:
//   LATENCY  initial latency count (single latency), doubled when RWDS is high at CA0
//   BURST_W  width of len_i; longest burst is 2^BURST_W words
//   RWR      read-write recovery cycles with CS# high
//   TIMEOUT  read watchdog limit in cycles (macro builds only)
//
// Ports:
//   clk_i, rst_i          clock (also the pad block word clock), sync active-high reset
//   req_i, rw_i, reg_i    request strobe, 1=read/0=write, 1=register/0=memory space
//   addr_i, len_i         16-bit word address, burst length minus one
//   wdat_i, wready_o      first-word-fall-through write data and its consume strobe
//   rdat_o, rvalid_o      read word and its valid strobe (same cycle as rwds_valid_i)
//   busy_o, done_o, err_o transaction in progress, end pulse, read timeout pulse
//   cs_n_o, ck_en_o       HyperBus CS# and memory clock enable
//   dq_oe_o, dq_o, dq_i   pad output enable, word to pads, word from pads
//   rwds_i, rwds_valid_i  RWDS level (latency select), strobe-captured word flag
//
// Only the state and counters are registers; every output is decoded from them
// combinationally so that read data passes through with zero latency and the
// write data path follows the FWFT source directly.

module hyperbus_ctrl #(
    parameter int unsigned LATENCY = 6,
    parameter int unsigned BURST_W = 8,
    parameter int unsigned RWR     = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               rw_i,
    input  logic               reg_i,
    input  logic [31:0]        addr_i,
    input  logic [BURST_W-1:0] len_i,
    input  logic [15:0]        wdat_i,
    output logic               wready_o,
    output logic [15:0]        rdat_o,
    output logic               rvalid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               cs_n_o,
    output logic               ck_en_o,
    output logic               dq_oe_o,
    output logic [15:0]        dq_o,
    input  logic [15:0]        dq_i,
    input  logic               rwds_i,
    input  logic               rwds_valid_i
);

    localparam int unsigned LAT_W = $clog2(2 * LATENCY + 1);
    localparam int unsigned CNT_W = BURST_W + 1;
    localparam int unsigned RCV_W = (RWR > 1) ? $clog2(RWR) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CSS,
        S_CA0,
        S_CA1,
        S_CA2,
        S_LAT,
        S_WR,
        S_RD,
        S_CSH,
        S_RCV
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched request
    logic               rw_q;
    logic               reg_q;
    logic [31:0]        addr_q;
    logic [BURST_W-1:0] len_q;

    // Phase counters
    logic [LAT_W-1:0]   lc_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [RCV_W-1:0]   rcv_cnt;

    logic [47:0]        ca;
    logic               lat_last;
    logic               burst_last;
    logic               rcv_last;
    logic               timeout_c;

    // Command/address: rw, space, linear burst, upper address, reserved, low address
    assign ca = {rw_q, reg_q, 1'b1, addr_q[31:3], 13'd0, addr_q[2:0]};

    assign lat_last   = (lat_cnt == (lc_q - LAT_W'(1)));
    // beat_cnt holds the number of words already transferred
    assign burst_last = (beat_cnt == CNT_W'(len_q));
    assign rcv_last   = (rcv_cnt == RCV_W'(RWR - 1));

`ifdef HYPERBUS_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Strobe-less cycle counter, cleared by every strobe and outside RD
    always_ff @(posedge clk_i) begin
        if (rst_i || (state != S_RD) || rwds_valid_i) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_c = (state == S_RD) && !rwds_valid_i
                       && (to_cnt == TO_W'(TIMEOUT - 1));

    // err_o shows up in the first CSH cycle after the watchdog fires
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_c;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_c = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch and phase counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rw_q     <= 1'b0;
            reg_q    <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            lc_q     <= '0;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            rcv_cnt  <= '0;
        end else begin
            if ((state == S_IDLE) && req_i) begin
                rw_q   <= rw_i;
                reg_q  <= reg_i;
                addr_q <= addr_i;
                len_q  <= len_i;
            end

            // RWDS high during CA0 asks for double latency
            if (state == S_CA0) begin
                lc_q <= rwds_i ? LAT_W'(2 * LATENCY) : LAT_W'(LATENCY);
            end

            lat_cnt <= (state == S_LAT) ? lat_cnt + LAT_W'(1) : '0;

            // Writes move one word per cycle; reads only on captured strobes
            if ((state == S_WR) || ((state == S_RD) && rwds_valid_i)) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end else if ((state != S_WR) && (state != S_RD)) begin
                beat_cnt <= '0;
            end

            rcv_cnt <= (state == S_RCV) ? rcv_cnt + RCV_W'(1) : '0;
        end
    end

    // Next state and output decode
    always_comb begin
        state_nxt = state;
        busy_o    = (state != S_IDLE);
        cs_n_o    = 1'b1;
        ck_en_o   = 1'b0;
        dq_oe_o   = 1'b0;
        dq_o      = '0;
        wready_o  = 1'b0;
        rvalid_o  = 1'b0;
        rdat_o    = '0;
        done_o    = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_i) begin
                    state_nxt = S_CSS;
                end
            end

            S_CSS: begin
                cs_n_o    = 1'b0;
                state_nxt = S_CA0;
            end

            S_CA0: begin
                cs_n_o    = 1'b0;
                ck_en_o   = 1'b1;
                dq_oe_o   = 1'b1;
                dq_o      = ca[47:32];
                state_nxt = S_CA1;
            end

            S_CA1: begin
                cs_n_o    = 1'b0;
                ck_en_o   = 1'b1;
                dq_oe_o   = 1'b1;
                dq_o      = ca[31:16];
                state_nxt = S_CA2;
            end

            S_CA2: begin
                cs_n_o    = 1'b0;
                ck_en_o   = 1'b1;
                dq_oe_o   = 1'b1;
                dq_o      = ca[15:0];
                // Register writes carry no latency phase
                state_nxt = (!rw_q && reg_q) ? S_WR : S_LAT;
            end

            S_LAT: begin
                cs_n_o  = 1'b0;
                ck_en_o = 1'b1;
                dq_oe_o = !rw_q;
                if (lat_last) begin
                    state_nxt = rw_q ? S_RD : S_WR;
                end
            end

            S_WR: begin
                cs_n_o   = 1'b0;
                ck_en_o  = 1'b1;
                dq_oe_o  = 1'b1;
                dq_o     = wdat_i;
                wready_o = 1'b1;
                // A register write is always exactly one word
                if (burst_last || reg_q) begin
                    state_nxt = S_CSH;
                end
            end

            S_RD: begin
                cs_n_o  = 1'b0;
                ck_en_o = 1'b1;
                if (rwds_valid_i) begin
                    rvalid_o = 1'b1;
                    rdat_o   = dq_i;
                    if (burst_last) begin
                        state_nxt = S_CSH;
                    end
                end
                if (timeout_c) begin
                    state_nxt = S_CSH;
                end
            end

            S_CSH: begin
                cs_n_o    = 1'b0;
                state_nxt = S_RCV;
            end

            S_RCV: begin
                done_o = rcv_last;
                if (rcv_last) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
